mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- MEM-stage load/store unit sitting between the EX/MEM register and the MEM/WB register.
- Non-memory ops: passes write-back fields through combinationally.
- Loads/stores: runs a bus handshake to the data-side cache/storage hierarchy and holds `stallreq` until the access completes, so the pipeline controller freezes the upstream stages.
- Produces the `mem_*` fields (wd, wreg, wdata, hi, lo, whilo) that the MEM/WB register captures.

Parameters:
- TIMEOUT, 64: max cycles waiting for `bus_ack` before the access is aborted.
- TO_W, 7: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- mem_stall  in  1  controller stall bit for the MEM stage (stall[3]); 1 = MEM/EX-MEM frozen this cycle.
- i_wd  in  5  destination register.
- i_wreg  in  1  register write enable.
- i_wdata  in  32  ALU result (non-load data).
- i_hi  in  32  HI value from EX.
- i_lo  in  32  LO value from EX.
- i_whilo  in  1  HI/LO write enable.
- i_memop  in  4  memory op code; package encoding NONE, LB, LBU, LH, LHU, LW, SB, SH, SW.
- i_addr  in  32  effective address.
- i_sdata  in  32  store data, low-aligned.
- mem_wd  out  5  to MEM/WB.
- mem_wreg  out  1  to MEM/WB.
- mem_wdata  out  32  to MEM/WB.
- mem_hi  out  32  to MEM/WB.
- mem_lo  out  32  to MEM/WB.
- mem_whilo  out  1  to MEM/WB.
- stallreq  out  1  stall request to the pipeline controller.
- bus_req  out  1  access request, held until ack or abort.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word address; low 2 bits forced to 0.
- bus_sel  out  4  byte lane enables; bit3 = bits [31:24].
- bus_wdata  out  32  lane-replicated store data.
- bus_rdata  in  32  read data, valid when `bus_ack`.
- bus_ack  in  1  single-cycle completion pulse.
- exc_misalign  out  1  one-cycle pulse on a misaligned access.
- exc_buserr  out  1  one-cycle pulse on a timeout abort.

Behaviour:
- Reset:
  - While `rst`=1, all outputs are 0: `mem_*` = 0, `stallreq` = 0, `bus_*` outputs = 0, `exc_*` = 0.
  - State = IDLE, timeout counter = 0, data latch = 0.
  - `rst` asserted mid-access drops `bus_req` the next edge; no ack is consumed afterwards.
- Endianness and lanes (big-endian):
  - Byte at addr[1:0] = 00 occupies [31:24], sel = 1000; 01 → 0100; 10 → 0010; 11 → 0001.
  - Half at addr[1] = 0 → [31:16], sel = 1100; addr[1] = 1 → [15:0], sel = 0011.
  - Word → sel = 1111.
  - Store data is replicated across lanes: SB = {4{b}}, SH = {2{h}}.
- Load extraction: LB/LH sign-extend; LBU/LHU zero-extend; LW takes the word unchanged.
- Misaligned: LH/LHU/SH with addr[0] = 1, or LW/SW with addr[1:0] ≠ 00.
  - No bus request is issued; `exc_misalign` pulses for one cycle; `mem_wreg` is forced to 0.
  - The pulse repeats while `mem_stall` holds the instruction.
- States:
  - IDLE:
    - memop = NONE: outputs = inputs (pure pass-through), `stallreq` = 0.
    - Valid aligned memop: `stallreq` = 1 combinationally this cycle; next edge → BUSY with `bus_*` registered from the inputs; counter cleared.
  - BUSY:
    - `bus_req` = 1 with stable addr/sel/we/wdata; `stallreq` = 1; counter increments each cycle.
    - On `bus_ack`: latch the extended load data (store: latch `i_wdata`) → DONE; `bus_req` = 0 from the next cycle.
    - Counter reaching TIMEOUT-1 without ack: → DONE with `err` flag set; `exc_buserr` pulses; `bus_req` dropped.
    - `bus_ack` in the same cycle as the timeout: treated as success.
  - DONE:
    - `stallreq` = 0.
    - `mem_wdata` = latch; `mem_wreg` = `i_wreg` for loads, `i_wreg` for stores, 0 if `err`.
    - Other fields pass through.
    - `mem_stall` = 0 → IDLE next edge (MEM/WB captured the result). `mem_stall` = 1 → remain in DONE with no new request.
- Latency:
  - Non-memory op: 0 extra cycles.
  - Memory op: 2 + N cycles in MEM, where N = cycles from `bus_req` to `bus_ack` (N ≥ 1). Minimum 3 cycles.
- Stores: `mem_wreg` follows `i_wreg`, which is 0 for stores from the decoder.
- HI/LO fields are never modified by this block.

Decomposition:
- Shared package/header (alongside the existing `DISABLED`/`ENABLED` defines):
  - memop encodings (4-bit);
  - state encodings IDLE/BUSY/DONE;
  - lane-select constants.
- Natural sub-module: `mem_lane_align` (combinational).
  - Inputs: memop, addr[1:0], sdata, rdata.
  - Outputs: sel, replicated wdata, extended load data, misaligned flag.
- FSM and latches stay in the top module.

Test Plan:
- ADD r3 (wd = 3, wreg = 1, wdata = 0x1234) with memop NONE → same-cycle pass-through; `stallreq` = 0; no `bus_req`.
- LB addr 0x101, memory word 0x11F03344, ack 2 cycles after `bus_req`:
  - `bus_sel` = 0100, `bus_addr` = 0x100;
  - `mem_wdata` = 0xFFFFFFF0;
  - `stallreq` high for exactly 3 cycles.
- SH addr 0x202, sdata 0x0000ABCD, immediate ack:
  - `bus_we` = 1, `bus_sel` = 0011, `bus_wdata` = 0xABCDABCD;
  - `mem_wreg` = 0.
- LW addr 0x103 → `exc_misalign` pulse; `bus_req` never asserted; `mem_wreg` = 0; `stallreq` = 0.
- LW with no ack, TIMEOUT = 64:
  - `bus_req` high for 64 cycles, then drops;
  - `exc_buserr` pulses once; `mem_wreg` = 0; `stallreq` released.
- LHU addr 0x300 (word 0x8001xxxx) acked while `mem_stall` = 1 for 2 extra cycles:
  - stays in DONE with `mem_wdata` = 0x00008001 stable;
  - no second `bus_req`;
  - `rst` pulse afterwards returns all outputs to 0.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MEM-stage load/store unit: memory op codes, FSM states and
// byte-lane select patterns (big-endian, bit 3 = bits [31:24]).
package mem_access_unit_pkg;

  typedef enum logic [3:0] {
    MemNone = 4'd0,
    MemLb   = 4'd1,
    MemLbu  = 4'd2,
    MemLh   = 4'd3,
    MemLhu  = 4'd4,
    MemLw   = 4'd5,
    MemSb   = 4'd6,
    MemSh   = 4'd7,
    MemSw   = 4'd8
  } memop_e;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  localparam logic [3:0] SelWord   = 4'b1111;
  localparam logic [3:0] SelHalfHi = 4'b1100;
  localparam logic [3:0] SelHalfLo = 4'b0011;
  localparam logic [3:0] SelByte0  = 4'b1000;

  // Codes outside LB..SW are treated as non-memory ops.
  function automatic logic memop_is_mem(logic [3:0] op);
    return (op >= 4'(MemLb)) && (op <= 4'(MemSw));
  endfunction

  function automatic logic memop_is_store(logic [3:0] op);
    return (op == 4'(MemSb)) || (op == 4'(MemSh)) || (op == 4'(MemSw));
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-side bus between the MEM-stage unit (master) and the cache/storage hierarchy (slave).
interface mem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: lane selects, store replication, load extraction and
// misalignment detection for big-endian byte/half/word accesses.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [3:0]  memop,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic        misaligned
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    unique case (addr_lo)
      2'd0: rbyte = rdata[31:24];
      2'd1: rbyte = rdata[23:16];
      2'd2: rbyte = rdata[15:8];
      2'd3: rbyte = rdata[7:0];
    endcase
    rhalf = addr_lo[1] ? rdata[15:0] : rdata[31:16];

    sel        = '0;
    wdata      = '0;
    ldata      = '0;
    misaligned = 1'b0;
    case (memop)
      MemLb, MemLbu, MemSb: sel = SelByte0 >> addr_lo;
      MemLh, MemLhu, MemSh: begin
        sel        = addr_lo[1] ? SelHalfLo : SelHalfHi;
        misaligned = addr_lo[0];
      end
      MemLw, MemSw: begin
        sel        = SelWord;
        misaligned = |addr_lo;
      end
      default: ;
    endcase

    case (memop)
      MemLb:   ldata = {{24{rbyte[7]}}, rbyte};
      MemLbu:  ldata = {24'h0, rbyte};
      MemLh:   ldata = {{16{rhalf[15]}}, rhalf};
      MemLhu:  ldata = {16'h0, rhalf};
      MemLw:   ldata = rdata;
      MemSb:   wdata = {4{sdata[7:0]}};
      MemSh:   wdata = {2{sdata[15:0]}};
      MemSw:   wdata = sdata;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: passes write-back fields through and runs a stalling bus
// handshake (IDLE -> BUSY -> DONE) for loads and stores, with timeout abort.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned TO_W    = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_stall,
  input  logic [4:0]  i_wd,
  input  logic        i_wreg,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  input  logic        i_whilo,
  input  logic [3:0]  i_memop,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_sdata,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic        mem_whilo,
  output logic        stallreq,
  mem_access_unit_if.master bus,
  output logic        exc_misalign,
  output logic        exc_buserr
);

  state_e          state_q;
  logic [TO_W-1:0] cnt_q;
  logic [31:0]     latch_q;
  logic            err_q, buserr_q;
  logic            req_q, we_q;
  logic [31:0]     addr_q, wdata_q;
  logic [3:0]      sel_q;

  logic [3:0]  lane_sel;
  logic [31:0] lane_wdata, lane_ldata;
  logic        lane_mis, is_mem, start, misalign_now;

  mem_lane_align u_align (
    .memop     (i_memop),
    .addr_lo   (i_addr[1:0]),
    .sdata     (i_sdata),
    .rdata     (bus.bus_rdata),
    .sel       (lane_sel),
    .wdata     (lane_wdata),
    .ldata     (lane_ldata),
    .misaligned(lane_mis)
  );

  assign is_mem       = memop_is_mem(i_memop);
  assign start        = (state_q == StIdle) && is_mem && !lane_mis;
  assign misalign_now = (state_q == StIdle) && is_mem && lane_mis;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      latch_q  <= '0;
      err_q    <= 1'b0;
      buserr_q <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      sel_q    <= '0;
      wdata_q  <= '0;
    end else begin
      buserr_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StBusy;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            req_q   <= 1'b1;
            we_q    <= memop_is_store(i_memop);
            addr_q  <= {i_addr[31:2], 2'b00};
            sel_q   <= lane_sel;
            wdata_q <= lane_wdata;
          end
        end
        StBusy: begin
          // An ack coinciding with the final timeout cycle still counts as success.
          if (bus.bus_ack) begin
            latch_q <= we_q ? i_wdata : lane_ldata;
            req_q   <= 1'b0;
            state_q <= StDone;
          end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
            latch_q  <= '0;
            err_q    <= 1'b1;
            buserr_q <= 1'b1;
            req_q    <= 1'b0;
            state_q  <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          if (!mem_stall) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    mem_wd       = i_wd;
    mem_wreg     = i_wreg;
    mem_wdata    = i_wdata;
    mem_hi       = i_hi;
    mem_lo       = i_lo;
    mem_whilo    = i_whilo;
    stallreq     = start || (state_q == StBusy);
    exc_misalign = misalign_now;
    exc_buserr   = buserr_q;
    if (state_q == StDone) begin
      mem_wdata = latch_q;
      mem_wreg  = i_wreg & ~err_q;
    end else if (misalign_now) begin
      mem_wreg = 1'b0;
    end
    if (rst) begin
      mem_wd       = '0;
      mem_wreg     = 1'b0;
      mem_wdata    = '0;
      mem_hi       = '0;
      mem_lo       = '0;
      mem_whilo    = 1'b0;
      stallreq     = 1'b0;
      exc_misalign = 1'b0;
      exc_buserr   = 1'b0;
    end
  end

  assign bus.bus_req   = req_q & ~rst;
  assign bus.bus_we    = we_q & ~rst;
  assign bus.bus_addr  = rst ? '0 : addr_q;
  assign bus.bus_sel   = rst ? '0 : sel_q;
  assign bus.bus_wdata = rst ? '0 : wdata_q;

endmodule
